// File: rtl/bf_program_loader.sv
// Boot/run controller for the brainfuck core: streams a program from the serial
// receiver into code RAM, null-terminates it, then runs the core and feeds ','.
module bf_program_loader #(
  parameter int         addrSize_code  = 9,
  parameter logic [7:0] END_CHAR       = 8'h04,
  parameter int         RESTART_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  input  logic                     rerun,
  input  logic                     reload,
  output logic [addrSize_code-1:0] code_addr,
  output logic [7:0]               code_wdata,
  output logic                     code_we,
  input  logic [7:0]               code_rdata,
  input  logic [addrSize_code-1:0] core_addr_code,
  input  logic                     core_done,
  output logic                     core_reset_n,
  output logic                     core_rx_valid,
  output logic [7:0]               core_rx_data,
  output logic [1:0]               state,
  output logic [addrSize_code-1:0] prog_len,
  output logic                     overflow,
  output logic                     rx_overrun
);

  localparam int CNT_W = (RESTART_CYCLES < 2) ? 1 : $clog2(RESTART_CYCLES + 1);
  localparam logic [addrSize_code-1:0] PTR_LAST = '1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESTART_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [7:0] COMMA = 8'h2C;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_TERM = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [addrSize_code-1:0] ptr_q, ptr_d;
  logic [addrSize_code-1:0] addr_q, addr_d;
  logic [7:0]               wdata_q, wdata_d;
  logic                     we_q, we_d;
  logic                     core_reset_n_q, core_reset_n_d;
  logic                     rx_buf_valid_q, rx_buf_valid_d;
  logic [7:0]               rx_buf_data_q, rx_buf_data_d;
  logic [addrSize_code-1:0] prog_len_q, prog_len_d;
  logic                     overflow_q, overflow_d;
  logic                     rx_overrun_q, rx_overrun_d;
  logic [CNT_W-1:0]         restart_cnt_q, restart_cnt_d;
  logic                     comma_q, comma_d;
  logic [addrSize_code-1:0] last_addr_q, last_addr_d;
  logic                     consume;

  // The core has taken the buffered byte once it moves off a ',' instruction.
  assign consume = rx_buf_valid_q && comma_q && (core_addr_code != last_addr_q);

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    we_d           = 1'b0;
    core_reset_n_d = core_reset_n_q;
    rx_buf_valid_d = rx_buf_valid_q;
    rx_buf_data_d  = rx_buf_data_q;
    prog_len_d     = prog_len_q;
    overflow_d     = overflow_q;
    rx_overrun_d   = rx_overrun_q;
    restart_cnt_d  = restart_cnt_q;
    comma_d        = (code_rdata == COMMA);
    last_addr_d    = core_addr_code;

    case (state_q)
      S_LOAD: begin
        addr_d         = ptr_q;
        core_reset_n_d = 1'b0;
        rx_buf_valid_d = 1'b0;
        if (rx_valid) begin
          if (rx_data == END_CHAR || rx_data == 8'h00) begin
            state_d = S_TERM;
            we_d    = 1'b1;
            wdata_d = 8'h00;
          end else if (ptr_q == PTR_LAST) begin
            state_d    = S_TERM;
            we_d       = 1'b1;
            wdata_d    = 8'h00;
            overflow_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            wdata_d = rx_data;
            ptr_d   = ptr_q + 1'b1;
          end
        end
      end

      S_TERM: begin
        prog_len_d     = ptr_q;
        core_reset_n_d = 1'b1;
        state_d        = S_RUN;
      end

      S_RUN, S_HALT: begin
        if (consume) begin
          rx_buf_valid_d = 1'b0;
        end
        if (rx_valid) begin
          if (rx_buf_valid_q) begin
            rx_overrun_d = 1'b1;
          end else begin
            rx_buf_valid_d = 1'b1;
            rx_buf_data_d  = rx_data;
          end
        end
        if (restart_cnt_q != '0) begin
          restart_cnt_d = restart_cnt_q - 1'b1;
          if (restart_cnt_q == CNT_ONE) begin
            core_reset_n_d = 1'b1;
          end
        end
        // A restart also masks core_done, which is meaningless while the core is held.
        if (rerun) begin
          state_d        = S_RUN;
          restart_cnt_d  = CNT_LOAD;
          core_reset_n_d = 1'b0;
          rx_buf_valid_d = 1'b0;
        end else if (state_q == S_RUN && restart_cnt_q == '0 && core_done) begin
          state_d = S_HALT;
        end
      end

      default: state_d = S_LOAD;
    endcase

    if (reload) begin
      state_d        = S_LOAD;
      ptr_d          = '0;
      addr_d         = '0;
      we_d           = 1'b0;
      prog_len_d     = '0;
      overflow_d     = 1'b0;
      rx_overrun_d   = 1'b0;
      rx_buf_valid_d = 1'b0;
      core_reset_n_d = 1'b0;
      restart_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_LOAD;
      ptr_q          <= '0;
      addr_q         <= '0;
      wdata_q        <= 8'h00;
      we_q           <= 1'b0;
      core_reset_n_q <= 1'b0;
      rx_buf_valid_q <= 1'b0;
      rx_buf_data_q  <= 8'h00;
      prog_len_q     <= '0;
      overflow_q     <= 1'b0;
      rx_overrun_q   <= 1'b0;
      restart_cnt_q  <= '0;
      comma_q        <= 1'b0;
      last_addr_q    <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      we_q           <= we_d;
      core_reset_n_q <= core_reset_n_d;
      rx_buf_valid_q <= rx_buf_valid_d;
      rx_buf_data_q  <= rx_buf_data_d;
      prog_len_q     <= prog_len_d;
      overflow_q     <= overflow_d;
      rx_overrun_q   <= rx_overrun_d;
      restart_cnt_q  <= restart_cnt_d;
      comma_q        <= comma_d;
      last_addr_q    <= last_addr_d;
    end
  end

  assign code_addr     = (state_q == S_RUN || state_q == S_HALT) ? core_addr_code : addr_q;
  assign code_wdata    = wdata_q;
  assign code_we       = we_q;
  assign core_reset_n  = core_reset_n_q;
  assign core_rx_valid = rx_buf_valid_q;
  assign core_rx_data  = rx_buf_data_q;
  assign state         = state_q;
  assign prog_len      = prog_len_q;
  assign overflow      = overflow_q;
  assign rx_overrun    = rx_overrun_q;

endmodule
